// File: rtl/lut_mult_pkg.sv
// Shared types and widths for the LUT constant multiplier/divider datapath.
package lut_mult_pkg;

   // Divider control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIV_W   = 16;  // dividend / quotient width
   localparam int NIB_W   = 4;   // one quotient digit
   localparam int ENT_W   = 12;  // table entry and {r, nibble} width
   localparam int REM_W   = 8;   // partial remainder width
   localparam int CNT_W   = 2;   // digit counter width
   localparam int NUM_ENT = 16;  // number of constant multiples k*A_CONST

endpackage

// File: rtl/lut_digit_select.sv
// One radix-16 long-division step: picks the largest digit k with
// k*A_CONST <= v and returns the leftover v - k*A_CONST.
module lut_digit_select
   import lut_mult_pkg::*;
#(
   parameter int A_CONST = 2
) (
   input  logic [ENT_W-1:0] v,
   output logic [NIB_W-1:0] k,
   output logic [REM_W-1:0] r_next
);

   logic [NUM_ENT-1:0] fits;
   logic [REM_W-1:0]   entry_lo [NUM_ENT];

   // Multiple table: every entry is a constant, so each compare is a
   // comparator against a fixed value. Only the low byte of the chosen
   // entry is needed for the subtraction because the true difference is
   // always below A_CONST <= 255.
   generate
      for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_entry
         localparam logic [ENT_W-1:0] ENTRY = ENT_W'(gi * A_CONST);
         if (gi == 0) begin : g_zero
            assign fits[gi] = 1'b1;
         end else begin : g_cmp
            assign fits[gi] = (v >= ENTRY);
         end
         assign entry_lo[gi] = ENTRY[REM_W-1:0];
      end
   endgenerate

   // Priority select: fits[] is thermometer-coded, highest set index wins
   always_comb begin
      k = '0;
      for (int j = 0; j < NUM_ENT; j++) begin
         if (fits[j]) begin
            k = NIB_W'(j);
         end
      end
   end

   // Remainder modulo 256 is exact since the real difference is < A_CONST
   assign r_next = v[REM_W-1:0] - entry_lo[k];

endmodule

// File: rtl/lut_const_divider.sv
// Sequential divide-by-constant: one quotient nibble per clock, MSB first,
// with valid/ready handshakes on the dividend and result sides.
module lut_const_divider
   import lut_mult_pkg::*;
#(
   parameter int A_CONST = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DIV_W-1:0] C_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DIV_W-1:0] Q,
   output logic [REM_W-1:0] R,
   output logic             exact
);

   generate
      if (A_CONST < 1 || A_CONST > 255) begin : g_bad_const
         $error("lut_const_divider: A_CONST must be in 1..255");
      end
   endgenerate

   state_t           state_reg;
   state_t           state_next;
   logic [DIV_W-1:0] dividend_reg;
   logic [DIV_W-1:0] q_reg;
   logic [REM_W-1:0] r_reg;
   logic [REM_W-1:0] r_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [NIB_W-1:0] nibble;
   logic [NIB_W-1:0] k;
   logic [ENT_W-1:0] v;
   logic             load;
   logic             step;

   assign nibble = dividend_reg[{cnt_reg, 2'b00} +: NIB_W];
   assign v      = {r_reg, nibble};

   lut_digit_select #(
      .A_CONST(A_CONST)
   ) u_digit (
      .v      (v),
      .k      (k),
      .r_next (r_next)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state and handshake strobes; outputs depend on state only
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt_reg == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Dividend, quotient, remainder and digit counter
   always_ff @(posedge clk) begin
      if (rst) begin
         dividend_reg <= '0;
         q_reg        <= '0;
         r_reg        <= '0;
         cnt_reg      <= '0;
      end else if (load) begin
         dividend_reg <= C_in;
         q_reg        <= '0;
         r_reg        <= '0;
         cnt_reg      <= CNT_W'(3);
      end else if (step) begin
         q_reg   <= {q_reg[DIV_W-NIB_W-1:0], k};
         r_reg   <= r_next;
         cnt_reg <= cnt_reg - CNT_W'(1);
      end
   end

   assign Q     = q_reg;
   assign R     = r_reg;
   assign exact = (r_reg == '0);

endmodule

// File: tb/tb_lut_const_divider.sv
// Bench for lut_const_divider: several divisor instances, a driver that
// queues arithmetic expectations, and one monitor that checks everything.
module tb_lut_const_divider;

   localparam int NI = 8;
   localparam int AC [NI] = '{1, 2, 3, 7, 10, 13, 200, 255};

   typedef struct {
      int c;
      int q;
      int r;
      bit ex;
      int acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid_i  [NI];
   logic        in_ready_o  [NI];
   logic [15:0] c_in_i      [NI];
   logic        out_valid_o [NI];
   logic        out_ready_i [NI];
   logic [15:0] q_o         [NI];
   logic [7:0]  r_o         [NI];
   logic        exact_o     [NI];

   exp_t sb [NI][$];
   int   ready_mode [NI];   // 0 always ready, 1 random stalls, 2 held off
   int   cyc = 0;
   logic rst_seen = 1'b0;
   int   stim_timeouts = 0;
   bit   final_check = 1'b0;
   bit   final_done = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic        prev_valid [NI];
   logic        prev_ready [NI];
   logic [15:0] prev_q     [NI];
   logic [7:0]  prev_r     [NI];
   logic        prev_ex    [NI];
   int          wd         [NI];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   generate
      for (genvar gi = 0; gi < NI; gi++) begin : g_dut
         lut_const_divider #(
            .A_CONST(AC[gi])
         ) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_i[gi]),
            .in_ready  (in_ready_o[gi]),
            .C_in      (c_in_i[gi]),
            .out_valid (out_valid_o[gi]),
            .out_ready (out_ready_i[gi]),
            .Q         (q_o[gi]),
            .R         (r_o[gi]),
            .exact     (exact_o[gi])
         );
      end
   endgenerate

   task automatic chk(input bit ok, input string name, input string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   // Offer one dividend to instance i; expectation uses plain division
   task automatic send(input int i, input int c);
      exp_t e;
      int   t;
      c_in_i[i]     = 16'(c);
      in_valid_i[i] = 1'b1;
      t = 0;
      while (!in_ready_o[i] && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (in_ready_o[i]) begin
         e.c   = c;
         e.q   = c / AC[i];
         e.r   = c % AC[i];
         e.ex  = (e.r == 0);
         e.acc = cyc + 1;
         sb[i].push_back(e);
      end else begin
         stim_timeouts++;
      end
      @(negedge clk);
      in_valid_i[i] = 1'b0;
   endtask

   // Stimulus
   initial begin
      int rnd_idx [5];
      rnd_idx = '{0, 2, 4, 6, 7};
      for (int i = 0; i < NI; i++) begin
         in_valid_i[i] = 1'b0;
         c_in_i[i]     = '0;
         ready_mode[i] = 0;
      end
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed values
      send(1, 300);
      send(3, 65535);
      send(3, 0);
      send(7, 65535);
      send(5, 1000);
      send(0, 0);
      repeat (8) @(negedge clk);

      // Backpressure in DONE with ignored in_valid pulses
      ready_mode[3] = 2;
      send(3, 12345);
      repeat (4) @(negedge clk);
      for (int kk = 0; kk < 10; kk++) begin
         c_in_i[3]     = 16'($urandom);
         in_valid_i[3] = kk[0];
         @(negedge clk);
      end
      in_valid_i[3] = 1'b0;
      ready_mode[3] = 0;
      repeat (4) @(negedge clk);

      // Reset during the second RUN cycle, then a fresh dividend
      send(5, 4321);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(5, 1000);
      repeat (8) @(negedge clk);

      // Randomized dividends with random output stalls
      foreach (rnd_idx[n]) begin
         int i;
         int t;
         i = rnd_idx[n];
         ready_mode[i] = 1;
         send(i, 0);
         send(i, 65535);
         for (int m = 0; m < 398; m++) begin
            send(i, int'($urandom_range(0, 65535)));
         end
         t = 0;
         while (sb[i].size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
         end
         ready_mode[i] = 0;
      end

      repeat (4) @(negedge clk);
      final_check = 1'b1;
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Monitor and scoreboard
   initial begin
      for (int i = 0; i < NI; i++) begin
         out_ready_i[i] = 1'b0;
         prev_valid[i]  = 1'b0;
         prev_ready[i]  = 1'b0;
         prev_q[i]      = '0;
         prev_r[i]      = '0;
         prev_ex[i]     = 1'b0;
         wd[i]          = 0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (rst_seen) begin
               chk(out_valid_o[i] == 1'b0 && q_o[i] == 16'd0 && r_o[i] == 8'd0
                   && exact_o[i] == 1'b1 && in_ready_o[i] == 1'b1, "reset_state",
                   $sformatf("inst %0d got valid=%0d Q=%0d R=%0d exact=%0d in_ready=%0d, need 0/0/0/1/1",
                             i, out_valid_o[i], q_o[i], r_o[i], exact_o[i], in_ready_o[i]));
               while (sb[i].size() > 0 && sb[i][0].acc <= cyc) begin
                  void'(sb[i].pop_front());
               end
               prev_valid[i] = 1'b0;
               prev_ready[i] = 1'b0;
               wd[i] = 0;
               continue;
            end

            if (prev_valid[i] && !prev_ready[i]) begin
               chk(out_valid_o[i] && q_o[i] == prev_q[i] && r_o[i] == prev_r[i]
                   && exact_o[i] == prev_ex[i], "hold",
                   $sformatf("inst %0d got valid=%0d Q=%0d R=%0d exact=%0d, need 1/%0d/%0d/%0d",
                             i, out_valid_o[i], q_o[i], r_o[i], exact_o[i],
                             prev_q[i], prev_r[i], prev_ex[i]));
            end
            if (prev_valid[i] && prev_ready[i]) begin
               chk(!out_valid_o[i] && in_ready_o[i], "release",
                   $sformatf("inst %0d got valid=%0d in_ready=%0d, need 0/1",
                             i, out_valid_o[i], in_ready_o[i]));
            end
            if (out_valid_o[i]) begin
               chk(!in_ready_o[i], "in_ready_in_done",
                   $sformatf("inst %0d got in_ready=%0d, need 0", i, in_ready_o[i]));
            end
            if (out_valid_o[i] && !prev_valid[i]) begin
               chk(sb[i].size() > 0, "unexpected_out",
                   $sformatf("inst %0d got out_valid with %0d pending, need >0", i, sb[i].size()));
               if (sb[i].size() > 0) begin
                  chk(cyc - sb[i][0].acc == 4, "latency",
                      $sformatf("inst %0d got %0d clocks, need 4", i, cyc - sb[i][0].acc));
               end
            end

            case (ready_mode[i])
               0:       out_ready_i[i] = 1'b1;
               1:       out_ready_i[i] = ($urandom_range(0, 2) != 0);
               default: out_ready_i[i] = 1'b0;
            endcase

            if (out_valid_o[i] && out_ready_i[i] && sb[i].size() > 0) begin
               exp_t e;
               e = sb[i].pop_front();
               chk(int'(q_o[i]) == e.q && int'(r_o[i]) == e.r && exact_o[i] == e.ex, "result",
                   $sformatf("inst %0d A=%0d C=%0d got Q=%0d R=%0d exact=%0d, need Q=%0d R=%0d exact=%0d",
                             i, AC[i], e.c, q_o[i], r_o[i], exact_o[i], e.q, e.r, e.ex));
               chk(int'(q_o[i]) * AC[i] + int'(r_o[i]) == e.c && int'(r_o[i]) < AC[i], "identity",
                   $sformatf("inst %0d A=%0d got Q*A+R=%0d R=%0d, need %0d and R<%0d",
                             i, AC[i], int'(q_o[i]) * AC[i] + int'(r_o[i]), r_o[i], e.c, AC[i]));
               $display("txn inst=%0d A=%0d C=%0d Q=%0d R=%0d exact=%0d",
                        i, AC[i], e.c, q_o[i], r_o[i], exact_o[i]);
            end

            if (out_valid_o[i] || sb[i].size() == 0) begin
               wd[i] = 0;
            end else begin
               wd[i]++;
               chk(wd[i] <= 20, "watchdog",
                   $sformatf("inst %0d waited %0d clocks for a result, need <=20", i, wd[i]));
               if (wd[i] > 20) begin
                  sb[i].delete();
                  wd[i] = 0;
               end
            end

            prev_valid[i] = out_valid_o[i];
            prev_ready[i] = out_ready_i[i];
            prev_q[i]     = q_o[i];
            prev_r[i]     = r_o[i];
            prev_ex[i]    = exact_o[i];
         end

         if (final_check && !final_done) begin
            int pending;
            final_done = 1'b1;
            pending = 0;
            for (int i = 0; i < NI; i++) begin
               pending += sb[i].size();
            end
            chk(stim_timeouts == 0 && pending == 0, "final_drain",
                $sformatf("got %0d input timeouts and %0d pending results, need 0 and 0",
                          stim_timeouts, pending));
         end
      end
   end

endmodule
